// File: rtl/xgmii_ipg_msg_injector.sv
// rtl/xgmii_ipg_msg_injector.sv - carries queued side-band messages in XGMII inter-packet gaps
module xgmii_ipg_msg_injector #(
    parameter int          DATA_WIDTH  = 64,
    parameter int          CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int          MSG_WIDTH   = DATA_WIDTH - 8,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          GUARD_WORDS = 2,
    parameter int          MAX_PER_GAP = 4,
    parameter logic [7:0]  MSG_CHAR    = 8'h5C
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DATA_WIDTH-1:0]         xgmii_in_txd,
    input  logic [CTRL_WIDTH-1:0]         xgmii_in_txc,
    output logic [DATA_WIDTH-1:0]         xgmii_out_txd,
    output logic [CTRL_WIDTH-1:0]         xgmii_out_txc,
    input  logic [MSG_WIDTH-1:0]          msg_tdata,
    input  logic                          msg_tvalid,
    output logic                          msg_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   inj_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(GUARD_WORDS + 1);
    localparam int PW = $clog2(MAX_PER_GAP + 1);

    localparam logic [GW-1:0]         GUARD    = GW'(GUARD_WORDS);
    localparam logic [PW-1:0]         CAP      = PW'(MAX_PER_GAP);
    localparam logic [LW-1:0]         DEPTH    = LW'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] IDLE_TXD = {CTRL_WIDTH{8'h07}};

    typedef enum logic [1:0] {
        S_PASS,
        S_ARMED,
        S_INJECT_OK,
        S_CAPPED
    } mode_t;

    mode_t                state_q, state_d;
    logic [MSG_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [GW-1:0]        gap_cnt, gap_nxt;
    logic [PW-1:0]        per_gap, per_nxt;
    logic                 in_idle, fifo_empty, fifo_full, push, inject, mode_ready;
    logic [MSG_WIDTH-1:0] fifo_head;

    assign in_idle    = (xgmii_in_txc == '1) && (xgmii_in_txd == IDLE_TXD);
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == DEPTH);
    assign msg_tready = rst_n && !fifo_full;
    assign push       = msg_tvalid && msg_tready;
    assign fifo_head  = mem[rd_ptr];

    // The mode register mirrors the pre-update counters; after a disabled
    // cycle it reads PASS, so readiness falls back to the counters directly.
    always_comb begin
        state_d    = state_q;
        gap_nxt    = gap_cnt;
        per_nxt    = per_gap;
        mode_ready = (state_q == S_INJECT_OK) ||
                     (state_q == S_PASS && gap_cnt >= GUARD && per_gap < CAP);
        inject     = enable && in_idle && !fifo_empty && mode_ready;

        if (!in_idle) begin
            gap_nxt = '0;
            per_nxt = '0;
        end else begin
            if (gap_cnt < GUARD)
                gap_nxt = gap_cnt + GW'(1);
            if (inject && per_gap < CAP)
                per_nxt = per_gap + PW'(1);
        end

        if (!enable)
            state_d = S_PASS;
        else if (!in_idle || gap_nxt < GUARD)
            state_d = S_ARMED;
        else if (per_nxt == CAP)
            state_d = S_CAPPED;
        else
            state_d = S_INJECT_OK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_PASS;
            gap_cnt       <= '0;
            per_gap       <= '0;
            inj_count     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            xgmii_out_txd <= IDLE_TXD;
            xgmii_out_txc <= '1;
        end else begin
            state_q <= state_d;
            gap_cnt <= gap_nxt;
            per_gap <= per_nxt;

            if (inject) begin
                xgmii_out_txd <= {fifo_head, MSG_CHAR};
                xgmii_out_txc <= CTRL_WIDTH'(1);
                rd_ptr        <= rd_ptr + AW'(1);
                inj_count     <= inj_count + 16'd1;
            end else begin
                xgmii_out_txd <= xgmii_in_txd;
                xgmii_out_txc <= xgmii_in_txc;
            end

            if (push)
                wr_ptr <= wr_ptr + AW'(1);

            case ({push, inject})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= msg_tdata;
    end

endmodule

// File: tb/tb_xgmii_ipg_msg_injector.sv
// tb/tb_xgmii_ipg_msg_injector.sv - scoreboard bench for xgmii_ipg_msg_injector
module tb_xgmii_ipg_msg_injector;

    localparam logic [63:0] IDLE64 = 64'h0707070707070707;
    localparam logic [63:0] TERM64 = 64'hFD2233EE44EEEFFF;
    localparam logic [63:0] START64 = 64'hD5555555555555FB;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst64_n, en64, tvalid64, tready64;
    logic [63:0] in_txd64, out_txd64;
    logic [7:0]  in_txc64, out_txc64;
    logic [55:0] tdata64;
    logic [3:0]  level64;
    logic [15:0] inj64;

    logic        rst32_n, en32, tvalid32, tready32;
    logic [31:0] in_txd32, out_txd32;
    logic [3:0]  in_txc32, out_txc32;
    logic [23:0] tdata32;
    logic [2:0]  level32;
    logic [15:0] inj32;

    xgmii_ipg_msg_injector dut64 (
        .clk(clk), .rst_n(rst64_n), .enable(en64),
        .xgmii_in_txd(in_txd64), .xgmii_in_txc(in_txc64),
        .xgmii_out_txd(out_txd64), .xgmii_out_txc(out_txc64),
        .msg_tdata(tdata64), .msg_tvalid(tvalid64), .msg_tready(tready64),
        .fifo_level(level64), .inj_count(inj64)
    );

    xgmii_ipg_msg_injector #(
        .DATA_WIDTH(32), .FIFO_DEPTH(4), .GUARD_WORDS(1), .MAX_PER_GAP(65536)
    ) dut32 (
        .clk(clk), .rst_n(rst32_n), .enable(en32),
        .xgmii_in_txd(in_txd32), .xgmii_in_txc(in_txc32),
        .xgmii_out_txd(out_txd32), .xgmii_out_txc(out_txc32),
        .msg_tdata(tdata32), .msg_tvalid(tvalid32), .msg_tready(tready32),
        .fifo_level(level32), .inj_count(inj32)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_gap, m_per, n_inj_seen;
    logic [15:0] m_inj, inj_saved;
    logic [55:0] m_fifo[$];
    word_t       sb[$];
    logic [63:0] last_txd;
    logic [7:0]  last_txc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one input word, predict the output, compare it one cycle later.
    task automatic step64(input logic rst_in, input logic en, input logic [63:0] d,
                          input logic [7:0] c, input logic tv, input logic [55:0] td);
        word_t       w;
        logic        idle, inj, acc;
        logic [55:0] head;
        rst64_n = rst_in; en64 = en; in_txd64 = d; in_txc64 = c;
        tvalid64 = tv; tdata64 = td;
        #1;
        check_eq("tready", 64'(tready64), 64'(rst_in && m_fifo.size() < 8));
        if (!rst_in) begin
            w.d = IDLE64; w.c = 8'hFF;
            m_fifo.delete(); m_gap = 0; m_per = 0; m_inj = 16'd0;
        end else begin
            idle = (c == 8'hFF) && (d == IDLE64);
            inj  = en && idle && m_gap >= 2 && m_per < 4 && m_fifo.size() > 0;
            acc  = tv && m_fifo.size() < 8;
            if (inj) begin
                head = m_fifo.pop_front();
                w.d = {head, 8'h5C}; w.c = 8'h01;
                m_inj = m_inj + 16'd1;
                m_per++;
            end else begin
                w.d = d; w.c = c;
            end
            m_gap = idle ? ((m_gap < 2) ? m_gap + 1 : 2) : 0;
            if (!idle) m_per = 0;
            if (acc) m_fifo.push_back(td);
        end
        sb.push_back(w);
        @(posedge clk);
        @(negedge clk);
        w = sb.pop_front();
        last_txd = out_txd64; last_txc = out_txc64;
        check_eq("txd", out_txd64, w.d);
        check_eq("txc", 64'(out_txc64), 64'(w.c));
        check_eq("level", 64'(level64), 64'(m_fifo.size()));
        check_eq("inj_count", 64'(inj64), 64'(m_inj));
    endtask

    initial begin
        m_gap = 0; m_per = 0; m_inj = 16'd0;
        rst64_n = 1'b0; en64 = 1'b0; in_txd64 = IDLE64; in_txc64 = 8'hFF;
        tvalid64 = 1'b0; tdata64 = '0;
        rst32_n = 1'b0; en32 = 1'b0; in_txd32 = 32'h07070707; in_txc32 = 4'hF;
        tvalid32 = 1'b0; tdata32 = '0;
        @(negedge clk);

        step64(0, 0, IDLE64, 8'hFF, 0, '0);
        step64(0, 0, IDLE64, 8'hFF, 0, '0);
        repeat (5) step64(1, 0, IDLE64, 8'hFF, 0, '0);
        check_eq("idle_out", last_txd, IDLE64);
        check_eq("idle_inj", 64'(inj64), 64'd0);

        step64(1, 1, START64, 8'h01, 1, 56'h11223344556677);
        step64(1, 1, IDLE64, 8'hFF, 0, '0);
        step64(1, 1, IDLE64, 8'hFF, 0, '0);
        check_eq("guard_pass", last_txd, IDLE64);
        step64(1, 1, IDLE64, 8'hFF, 0, '0);
        check_eq("first_inj_txd", last_txd, 64'h112233445566775C);
        check_eq("first_inj_txc", 64'(last_txc), 64'h01);
        check_eq("first_inj_cnt", 64'(inj64), 64'd1);
        check_eq("first_inj_lvl", 64'(level64), 64'd0);

        for (int i = 0; i < 8; i++)
            step64(1, 1, {8{8'(i + 16)}}, 8'h00, 1, 56'hA0000000000000 | 56'(i));
        check_eq("full_level", 64'(level64), 64'd8);
        check_eq("full_tready", 64'(tready64), 64'd0);
        step64(1, 1, 64'h1111111111111111, 8'h00, 1, 56'hDEAD);
        check_eq("ninth_held", 64'(level64), 64'd8);

        n_inj_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step64(1, 1, IDLE64, 8'hFF, 0, '0);
            if (last_txc == 8'h01) n_inj_seen++;
        end
        check_eq("cap_count", 64'(n_inj_seen), 64'd4);
        check_eq("cap_level", 64'(level64), 64'd4);

        step64(1, 1, 64'h2222222222222222, 8'h00, 0, '0);
        step64(1, 1, IDLE64, 8'hFF, 0, '0);
        step64(1, 1, IDLE64, 8'hFF, 0, '0);
        step64(1, 1, IDLE64, 8'hFF, 1, 56'hC0C0C0);
        step64(1, 1, IDLE64, 8'hFF, 1, 56'hC1C1C1);
        check_eq("pushpop_level", 64'(level64), 64'd4);
        repeat (4) step64(1, 1, IDLE64, 8'hFF, 0, '0);

        step64(1, 1, TERM64, 8'h80, 1, 56'hE0E0E0);
        check_eq("term_pass", last_txd, TERM64);
        step64(1, 1, IDLE64, 8'hFF, 0, '0);
        check_eq("term_gap_idle", last_txd, IDLE64);
        step64(1, 1, START64, 8'h01, 0, '0);
        check_eq("start_txd", last_txd, START64);
        check_eq("start_txc", 64'(last_txc), 64'h01);

        inj_saved = inj64;
        step64(1, 0, 64'h3333333333333333, 8'h00, 0, '0);
        repeat (4) step64(1, 0, IDLE64, 8'hFF, 0, '0);
        check_eq("disabled_hold", 64'(inj64), 64'(inj_saved));

        step64(1, 1, 64'h4444444444444444, 8'h00, 1, 56'hF0F0F0);
        step64(1, 1, IDLE64, 8'hFF, 0, '0);
        step64(1, 1, IDLE64, 8'hFF, 0, '0);
        step64(1, 1, IDLE64, 8'hFF, 0, '0);
        check_eq("pre_rst_inj", 64'(last_txc), 64'h01);
        check_eq("pre_rst_lvl", 64'(level64), 64'd3);
        step64(0, 1, START64, 8'h01, 1, 56'hBADBAD);
        check_eq("rst_out_idle", last_txd, IDLE64);
        check_eq("rst_level", 64'(level64), 64'd0);
        check_eq("rst_inj", 64'(inj64), 64'd0);
        n_inj_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step64(1, 1, IDLE64, 8'hFF, 0, '0);
            if (last_txc == 8'h01) n_inj_seen++;
        end
        check_eq("no_stale", 64'(n_inj_seen), 64'd0);

        check_eq("w32_rst_txd", 64'(out_txd32), 64'h07070707);
        check_eq("w32_rst_txc", 64'(out_txc32), 64'hF);
        check_eq("w32_rst_tready", 64'(tready32), 64'd0);
        rst32_n = 1'b1; en32 = 1'b1; tvalid32 = 1'b1; tdata32 = 24'hABCDEF;
        @(posedge clk); @(negedge clk);
        tvalid32 = 1'b0;
        check_eq("w32_push_lvl", 64'(level32), 64'd1);
        @(posedge clk); @(negedge clk);
        check_eq("w32_inj_txd", 64'(out_txd32), 64'hABCDEF5C);
        check_eq("w32_inj_txc", 64'(out_txc32), 64'h1);
        check_eq("w32_inj_cnt", 64'(inj32), 64'd1);
        check_eq("w32_inj_lvl", 64'(level32), 64'd0);
        tvalid32 = 1'b1; tdata32 = 24'h123456;
        @(posedge clk); @(negedge clk);
        check_eq("w32_refill", 64'(level32), 64'd1);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check_eq("w32_cnt_max", 64'(inj32), 64'hFFFF);
        @(posedge clk); @(negedge clk);
        check_eq("w32_cnt_wrap", 64'(inj32), 64'd0);
        check_eq("w32_wrap_txd", 64'(out_txd32), 64'h1234565C);
        check_eq("w32_steady_lvl", 64'(level32), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xgmii_ipg_msg_injector.md
Name: xgmii_ipg_msg_injector

Overview:
- Sits on the XGMII TX path between the MAC and the eth_phy_10g encoder.
- Buffers short side-band messages in a FIFO and carries each one in a single XGMII word during the inter-packet gap.
- An injected word is lane 0 = control character MSG_CHAR, remaining lanes = message bytes. Frame words pass through untouched.
- Parametrised in width, FIFO depth, guard gap and per-gap injection cap.

Parameters:
- DATA_WIDTH, 64, XGMII data width; 32 or 64.
- CTRL_WIDTH, DATA_WIDTH/8, XGMII control width.
- MSG_WIDTH, DATA_WIDTH-8, message payload bits carried per injected word.
- FIFO_DEPTH, 8, message FIFO entries; power of 2, minimum 2.
- GUARD_WORDS, 2, consecutive all-idle input words required before the first injection in a gap; minimum 1.
- MAX_PER_GAP, 4, maximum injected words per gap; minimum 1.
- MSG_CHAR, 8'h5C, control character placed in lane 0 of an injected word.

Ports:
- clk, input, 1, single clock.
- rst_n, input, 1, synchronous active-low reset.
- enable, input, 1, 1 = injection allowed; 0 = pure pass-through, FIFO contents held.
- xgmii_in_txd, input, DATA_WIDTH, from MAC.
- xgmii_in_txc, input, CTRL_WIDTH, from MAC.
- xgmii_out_txd, output, DATA_WIDTH, to PHY.
- xgmii_out_txc, output, CTRL_WIDTH, to PHY.
- msg_tdata, input, MSG_WIDTH, message payload.
- msg_tvalid, input, 1, message valid.
- msg_tready, output, 1, FIFO can accept.
- fifo_level, output, $clog2(FIFO_DEPTH)+1, current occupancy.
- inj_count, output, 16, injected-word counter; wraps at 16'hFFFF to 0.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low; rst_n is sampled on the rising edge of clk.
- Reset values:
  - xgmii_out_txd = all bytes 8'h07; xgmii_out_txc = all ones.
  - FIFO emptied, fifo_level = 0, msg_tready = 0 during reset.
  - inj_count = 0, gap_cnt = 0, per_gap = 0.
- Reset asserted mid-message or mid-injection:
  - The queued message is discarded; no partial word is emitted.
  - The next output word is idle.
- Latency: exactly 1 cycle, input to registered output, in all modes.
- Idle word: txc all ones and every byte 8'h07. Any other word is non-idle.
- gap_cnt:
  - Increments on an idle input word, saturating at GUARD_WORDS.
  - Clears to 0 on any non-idle input word.
- per_gap:
  - Clears to 0 on any non-idle input word.
  - Increments on each injection, saturating at MAX_PER_GAP.
- Inject condition, evaluated per cycle on the current input:
  - enable = 1, input word idle, gap_cnt (before update) >= GUARD_WORDS, per_gap < MAX_PER_GAP, FIFO non-empty.
  - When true:
    - out_txd = {fifo_head, MSG_CHAR}; MSG_CHAR occupies bits [7:0] and the message occupies bits [DATA_WIDTH-1:8], LSB first.
    - out_txc = {CTRL_WIDTH-1 zeros, 1}.
    - FIFO pops, inj_count increments.
  - Otherwise the input is copied to the output.
- Injected words count as idle for gap_cnt, because the input word was idle.
- Injection never replaces a non-idle word. A word containing 0xFD terminate resets the gap.
- FIFO:
  - msg_tready = !full (and rst_n high).
  - A push occurs when msg_tvalid & msg_tready.
  - A simultaneous push and pop when not full leaves fifo_level unchanged.
  - No push is accepted while full; the pop that cycle frees an entry, which becomes visible on the next cycle.
  - Pop on empty is impossible because the inject condition requires non-empty.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_level updates registered, 1 cycle after the handshake.
- enable deasserted mid-gap: no further injections. Counters keep tracking the input stream.
- Mode FSM, state register:
  - PASS: enable = 0, or reset.
  - ARMED: enable = 1 and gap_cnt < GUARD_WORDS.
  - INJECT_OK: gap_cnt >= GUARD_WORDS and per_gap < MAX_PER_GAP.
  - CAPPED: per_gap = MAX_PER_GAP.
  - Any non-idle input returns to ARMED when enabled, or to PASS when disabled.

Test Plan:
- Reset, then 5 idle words with an empty FIFO:
  - Out equals in, delayed 1 cycle.
  - Out = 64'h0707070707070707, txc = 8'hFF.
  - inj_count = 0.
- Push msg 56'h11223344556677, then idle words with enable = 1:
  - The first two output idles pass through.
  - The third output word = 64'h112233445566775C with txc = 8'h01.
  - inj_count = 1, fifo_level returns to 0.
- Fill the FIFO with 8 messages:
  - msg_tready drops once fifo_level = 8.
  - A 9th valid is held, not accepted.
  - A gap of 20 idles injects exactly 4 words (cap); fifo_level = 4.
- Terminate word 64'hFD2233EE44EEEFFF (txc = 8'h80), then 1 idle, then start 64'hD5555555555555FB (txc = 8'h01), with a pending message:
  - No injection, because the guard is not met.
  - The frame passes bit-exact.
- Injection in progress with 3 queued messages, then rst_n = 0 for 1 cycle:
  - The next output is idle.
  - fifo_level = 0, inj_count = 0.
  - No stale message appears after release.
- DATA_WIDTH = 32, GUARD_WORDS = 1:
  - msg 24'hABCDEF is injected as 32'hABCDEF5C with txc = 4'h1 after 1 idle.
  - A 65536th injection wraps inj_count to 0.
